// File: rtl/aes_roundkey_store.sv
// -----------------------------------------------------------------------------
// aes_roundkey_store
//
// Purpose:
//   Captures an AES key schedule (R+1 round keys of N bits) produced by the
//   key-expansion block. Once the schedule is complete, it replays the keys to a
//   round datapath. Keys stream in encrypt order (0..R) or decrypt order (R..0),
//   and each key waits for a valid/ready handshake.
//
// Configuration macro:
//   AES_RKS_ZEROIZE_EN - when defined, clear_i walks every entry and writes
//                        zero, one entry per cycle, before the block returns to
//                        IDLE. When undefined, clear_i only invalidates the
//                        schedule and leaves the stored entries untouched.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   fill_start_i   in   pulse: start capturing a new schedule at index 0
//   key_valid_i    in   key_i carries the next round key
//   key_i          in   round key from key expansion (N bits)
//   stream_start_i in   pulse: start streaming the stored schedule
//   dir_i          in   stream order sampled with stream_start_i (0 enc, 1 dec)
//   rk_ready_i     in   consumer accepts rk_o this cycle
//   clear_i        in   pulse: invalidate (or zeroize) the schedule
//   rk_o           out  current streamed round key (N bits)
//   rk_valid_o     out  rk_o is valid
//   rk_idx_o       out  index of the key on rk_o
//   last_o         out  rk_o is the final key of the stream
//   full_o         out  all R+1 keys captured and readable
//   busy_o         out  block is in FILL, STREAM or ZERO
// -----------------------------------------------------------------------------
module aes_roundkey_store #(
    parameter int R = 10,
    parameter int N = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_start_i,
    input  logic                     key_valid_i,
    input  logic [N-1:0]             key_i,
    input  logic                     stream_start_i,
    input  logic                     dir_i,
    input  logic                     rk_ready_i,
    input  logic                     clear_i,
    output logic [N-1:0]             rk_o,
    output logic                     rk_valid_o,
    output logic [$clog2(R+1)-1:0]   rk_idx_o,
    output logic                     last_o,
    output logic                     full_o,
    output logic                     busy_o
);

    localparam int IW = $clog2(R+1);
    localparam logic [IW-1:0] LAST_IDX = IW'(R);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_FULL   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
`ifdef AES_RKS_ZEROIZE_EN
    localparam logic [2:0] ST_ZERO   = 3'd4;
`endif

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] wptr_q, wptr_d;
    logic [IW-1:0] rptr_q, rptr_d;
    logic          dir_q, dir_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;

    logic [N-1:0]  mem_q [0:R];
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [N-1:0]  mem_wdata;

    logic          last_w;

    // The final key of a stream is index R going up, or index 0 going down.
    // Only a valid key can be flagged as last.
    always_comb begin
        last_w = 1'b0;
        if (valid_q) begin
            if (dir_q) begin
                last_w = (rptr_q == '0);
            end else begin
                last_w = (rptr_q == LAST_IDX);
            end
        end
    end

    // Next-state logic for the control FSM, the pointers and the storage write port.
    // clear_i is checked before the state case so that it wins in every state.
    // The write pointer is shared: it tracks captured keys in FILL and the
    // entry being wiped in ZERO.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        dir_d     = dir_q;
        full_d    = full_q;
        valid_d   = valid_q;
        mem_we    = 1'b0;
        mem_waddr = wptr_q;
        mem_wdata = key_i;

        if (clear_i) begin
`ifdef AES_RKS_ZEROIZE_EN
            state_d = ST_ZERO;
            wptr_d  = '0;
`else
            state_d = ST_IDLE;
`endif
            full_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fill_start_i) begin
                        state_d = ST_FILL;
                        wptr_d  = '0;
                        full_d  = 1'b0;
                    end
                end
                ST_FILL: begin
                    if (fill_start_i) begin
                        wptr_d = '0;
                    end else if (key_valid_i) begin
                        mem_we = 1'b1;
                        if (wptr_q == LAST_IDX) begin
                            state_d = ST_FULL;
                            full_d  = 1'b1;
                        end else begin
                            wptr_d = wptr_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (fill_start_i) begin
                        state_d = ST_FILL;
                        wptr_d  = '0;
                        full_d  = 1'b0;
                    end else if (stream_start_i) begin
                        state_d = ST_STREAM;
                        dir_d   = dir_i;
                        rptr_d  = dir_i ? LAST_IDX : '0;
                        valid_d = 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (valid_q && rk_ready_i) begin
                        if (last_w) begin
                            state_d = ST_FULL;
                            valid_d = 1'b0;
                        end else if (dir_q) begin
                            rptr_d = rptr_q - 1'b1;
                        end else begin
                            rptr_d = rptr_q + 1'b1;
                        end
                    end
                end
`ifdef AES_RKS_ZEROIZE_EN
                ST_ZERO: begin
                    mem_we    = 1'b1;
                    mem_wdata = '0;
                    if (wptr_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        wptr_d  = '0;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers. Reset abandons any fill or stream in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            dir_q   <= 1'b0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            dir_q   <= dir_d;
            full_q  <= full_d;
            valid_q <= valid_d;
        end
    end

    // Key storage. Every entry resets to zero so no stale key survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= R; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // busy_o covers every state in which the block is doing work.
    always_comb begin
        busy_o = (state_q == ST_FILL) || (state_q == ST_STREAM);
`ifdef AES_RKS_ZEROIZE_EN
        if (state_q == ST_ZERO) begin
            busy_o = 1'b1;
        end
`endif
    end

    // rk_o is driven only while the key is valid, so an invalidated schedule
    // never shows up on the output.
    assign rk_o       = valid_q ? mem_q[rptr_q] : '0;
    assign rk_valid_o = valid_q;
    assign rk_idx_o   = rptr_q;
    assign last_o     = last_w;
    assign full_o     = full_q;

endmodule

// File: tb/tb_aes_roundkey_store.sv
// -----------------------------------------------------------------------------
// tb_aes_roundkey_store
//
// Purpose:
//   Self-checking bench for aes_roundkey_store (R=10, N=128). A reference model
//   holds the schedule as a plain array of captured keys. Each stream is checked
//   as an ordered walk over that array, and handshakes advance the walk.
//   Honors AES_RKS_ZEROIZE_EN for the timing of clear_i.
// -----------------------------------------------------------------------------
module tb_aes_roundkey_store;

    localparam int R  = 10;
    localparam int N  = 128;
    localparam int IW = $clog2(R+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          fillStart;
    logic          keyValid;
    logic [N-1:0]  keyIn;
    logic          streamStart;
    logic          dir;
    logic          rkReady;
    logic          clear;
    logic [N-1:0]  rkOut;
    logic          rkValid;
    logic [IW-1:0] rkIdx;
    logic          lastOut;
    logic          fullOut;
    logic          busyOut;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] refKeys [0:R];

    aes_roundkey_store #(.R(R), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .fill_start_i   (fillStart),
        .key_valid_i    (keyValid),
        .key_i          (keyIn),
        .stream_start_i (streamStart),
        .dir_i          (dir),
        .rk_ready_i     (rkReady),
        .clear_i        (clear),
        .rk_o           (rkOut),
        .rk_valid_o     (rkValid),
        .rk_idx_o       (rkIdx),
        .last_o         (lastOut),
        .full_o         (fullOut),
        .busy_o         (busyOut)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Global time limit, so that a stuck design cannot hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change 1 ns after a rising edge and outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fs, input logic kv, input logic [N-1:0] k,
                                 input logic ss, input logic d, input logic rdy,
                                 input logic clr);
        fillStart   = fs;
        keyValid    = kv;
        keyIn       = k;
        streamStart = ss;
        dir         = d;
        rkReady     = rdy;
        clear       = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic expValid,
                               input logic expFull, input logic expBusy);
        checkOutput({tag, "_valid"}, N'(rkValid), N'(expValid));
        checkOutput({tag, "_full"},  N'(fullOut), N'(expFull));
        checkOutput({tag, "_busy"},  N'(busyOut), N'(expBusy));
    endtask

    // Capture a whole schedule with random gaps on key_valid_i. Keys are either
    // the index itself or random. stream_start_i can be injected mid-fill.
    task automatic fillSchedule(input bit seqKeys, input bit injectStream);
        int i;
        int cyc;
        logic kv;
        logic [N-1:0] k;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkStatus("fill_enter", 1'b0, 1'b0, 1'b1);
        i = 0;
        cyc = 0;
        while (i <= R && cyc < 200) begin
            checkStatus("fill_run", 1'b0, 1'b0, 1'b1);
            kv = ($urandom_range(0, 3) != 0);
            k  = seqKeys ? N'(i) : {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(1'b0, kv, k, injectStream && (cyc == 3), 1'b0, 1'b0, 1'b0);
            step();
            if (kv) begin
                refKeys[i] = k;
                i++;
            end
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_progress", N'(i), N'(R + 1));
        checkStatus("fill_done", 1'b0, 1'b1, 1'b0);
    endtask

    // Stream the schedule in direction d. readyMode: 0 always ready,
    // 1 alternating 1,0, 2 random. fillAt injects fill_start_i on that cycle.
    // clearAt pulses clear_i when the walk reaches that position.
    task automatic streamSchedule(input logic d, input int readyMode,
                                  input int fillAt, input int clearAt);
        int p;
        int cyc;
        int expIdx;
        logic rdy;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, d, 1'b0, 1'b0);
        step();
        p = 0;
        cyc = 0;
        while (p <= R && cyc < 100) begin
            expIdx = d ? (R - p) : p;
            checkOutput("rk_valid", N'(rkValid), N'(1));
            checkOutput("rk_idx",   N'(rkIdx),   N'(expIdx));
            checkOutput("rk_key",   rkOut,       refKeys[expIdx]);
            checkOutput("rk_last",  N'(lastOut), N'(p == R));
            if (p == clearAt) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b0, d, 1'b1, 1'b1);
                step();
                applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput("clr_valid", N'(rkValid), N'(0));
                checkOutput("clr_full",  N'(fullOut), N'(0));
`ifdef AES_RKS_ZEROIZE_EN
                checkOutput("zero_busy_first", N'(busyOut), N'(1));
                repeat (R) step();
                checkOutput("zero_busy_last", N'(busyOut), N'(1));
                step();
                checkOutput("zero_idle", N'(busyOut), N'(0));
                for (int j = 0; j <= R; j++) refKeys[j] = '0;
`else
                checkOutput("clr_idle", N'(busyOut), N'(0));
`endif
                return;
            end
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(cyc == fillAt, 1'b0, '0, 1'b0, d, rdy, 1'b0);
            step();
            if (rdy) p++;
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stream_progress", N'(p), N'(R + 1));
        checkStatus("stream_done", 1'b0, 1'b1, 1'b0);
        checkOutput("stream_done_last", N'(lastOut), N'(0));
    endtask

    // Directed sequence: reset, fill and stream in both directions, ignored
    // inputs, fill/stream collision, clear mid-stream, reset mid-fill, then
    // randomized rounds.
    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= R; j++) refKeys[j] = '0;
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_rk",    rkOut,         '0);
        checkOutput("rst_idx",   N'(rkIdx),     N'(0));
        checkOutput("rst_last",  N'(lastOut),   N'(0));
        checkStatus("rst", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        checkStatus("post_rst", 1'b0, 1'b0, 1'b0);

        fillSchedule(1'b1, 1'b0);
        streamSchedule(1'b0, 0, -1, -1);
        streamSchedule(1'b1, 1, -1, -1);

        fillSchedule(1'b0, 1'b1);
        streamSchedule(1'b0, 2, 3, -1);
        streamSchedule(1'b1, 2, -1, -1);

        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkStatus("fill_wins", 1'b0, 1'b0, 1'b1);
        fillSchedule(1'b0, 1'b0);

        streamSchedule(1'b0, 0, -1, 4);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkStatus("clr_stream_ignored", 1'b0, 1'b0, 1'b0);

        fillSchedule(1'b0, 1'b0);
        streamSchedule(1'b1, 2, -1, -1);

        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
                          1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_rk",   rkOut,       '0);
        checkOutput("midrst_idx",  N'(rkIdx),   N'(0));
        checkOutput("midrst_last", N'(lastOut), N'(0));
        checkStatus("midrst", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkStatus("midrst_stream_ignored", 1'b0, 1'b0, 1'b0);
        fillSchedule(1'b0, 1'b0);
        streamSchedule(1'b0, 2, -1, -1);

        for (int r = 0; r < 3; r++) begin
            fillSchedule(1'b0, 1'($urandom_range(0, 1)));
            streamSchedule(1'($urandom_range(0, 1)), 2, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
